// File: rtl/hack_io_pkg.sv
// Shared definitions for the Hack memory-mapped I/O controller: register
// offsets inside the I/O window and the address-decode selector type.
package hack_io_pkg;

  localparam int OFS_SW   = 0;
  localparam int OFS_BTN  = 1;
  localparam int OFS_EVT  = 2;
  localparam int OFS_MS   = 3;
  localparam int OFS_OUT0 = 4;

  typedef enum logic [2:0] {
    SEL_RAM,
    SEL_SW,
    SEL_BTN,
    SEL_EVT,
    SEL_MS,
    SEL_OUT,
    SEL_NONE
  } io_sel_e;

endpackage

// File: rtl/io_sync.sv
// Flop-chain synchroniser for asynchronous board inputs. A change on d
// appears on q after exactly STAGES rising clock edges.
module io_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] chain;

  // Shift the raw input through the chain; stage 0 is the only metastable one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/mmio_io_controller.sv
// Memory-mapped I/O controller between the Hack CPU data port and the data
// RAM / board I/O. Decodes RAM vs. I/O space, synchronises switches and
// buttons, keeps sticky button-press flags, a millisecond counter and a set
// of output registers.
//
// Bus semantics: the CPU port has no valid/ready pair. writeM is a
// single-cycle strobe qualified by addressM and committed at the next rising
// clk; reads are always ready and are a pure combinational function of
// addressM and the current register state (no wait states).
module mmio_io_controller
  import hack_io_pkg::*;
#(
  parameter int          DATA_W      = 16,
  parameter int          RAM_AW      = 14,
  parameter logic [14:0] IO_BASE     = 15'h6000,
  parameter int          BTN_W       = 5,
  parameter int          N_OUT       = 2,
  parameter int          SYNC_STAGES = 2,
  parameter int          CLK_HZ      = 100_000_000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [14:0]                  addressM,
  input  logic [DATA_W-1:0]            outM,
  input  logic                         writeM,
  output logic [DATA_W-1:0]            inM,
  output logic [RAM_AW-1:0]            ram_addr,
  output logic [DATA_W-1:0]            ram_data_in,
  output logic                         ram_we,
  input  logic [DATA_W-1:0]            ram_data_out,
  input  logic [DATA_W-1:0]            sw_raw,
  input  logic [BTN_W-1:0]             btn_raw,
  output logic [N_OUT-1:0][DATA_W-1:0] out_reg,
  output logic [N_OUT-1:0]             out_upd
);

  localparam int PRESC   = CLK_HZ / 1000;
  localparam int PRESC_W = (PRESC > 1) ? $clog2(PRESC) : 1;

  io_sel_e             sel;
  logic [14:0]         io_off;
  logic [N_OUT-1:0]    out_hit;
  logic [DATA_W-1:0]   sw_sync;
  logic [BTN_W-1:0]    btn_sync;
  logic [BTN_W-1:0]    btn_prev;
  logic [BTN_W-1:0]    set_mask;
  logic [BTN_W-1:0]    evt;
  logic [DATA_W-1:0]   ms;
  logic [PRESC_W-1:0]  presc;
  logic                tick;
  logic                we_evt;
  logic                we_ms;

  io_sync #(.WIDTH(DATA_W), .STAGES(SYNC_STAGES)) u_sw_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sw_raw),
    .q     (sw_sync)
  );

  io_sync #(.WIDTH(BTN_W), .STAGES(SYNC_STAGES)) u_btn_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn_raw),
    .q     (btn_sync)
  );

  // Address decode: bit 14 clear is RAM; the screen hole below IO_BASE and
  // any unmapped offset in the I/O window fall through to SEL_NONE.
  always_comb begin
    sel     = SEL_NONE;
    io_off  = addressM - IO_BASE;
    out_hit = '0;
    if (!addressM[14]) begin
      sel = SEL_RAM;
    end else if (addressM >= IO_BASE) begin
      if (io_off == 15'(OFS_SW)) begin
        sel = SEL_SW;
      end else if (io_off == 15'(OFS_BTN)) begin
        sel = SEL_BTN;
      end else if (io_off == 15'(OFS_EVT)) begin
        sel = SEL_EVT;
      end else if (io_off == 15'(OFS_MS)) begin
        sel = SEL_MS;
      end else if (io_off >= 15'(OFS_OUT0) && io_off < 15'(OFS_OUT0 + N_OUT)) begin
        sel = SEL_OUT;
      end
    end
    for (int i = 0; i < N_OUT; i++) begin
      out_hit[i] = (sel == SEL_OUT) && (io_off == 15'(OFS_OUT0 + i));
    end
  end

  assign ram_addr    = addressM[RAM_AW-1:0];
  assign ram_data_in = outM;
  assign ram_we      = writeM && (sel == SEL_RAM);
  assign we_evt      = writeM && (sel == SEL_EVT);
  assign we_ms       = writeM && (sel == SEL_MS);
  assign set_mask    = btn_sync & ~btn_prev;
  assign tick        = (presc == PRESC_W'(PRESC - 1));

  // Button edge capture: flags are sticky; a new edge beats a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_prev <= '0;
      evt      <= '0;
    end else begin
      btn_prev <= btn_sync;
      if (we_evt) begin
        evt <= (evt & ~outM[BTN_W-1:0]) | set_mask;
      end else begin
        evt <= evt | set_mask;
      end
    end
  end

  // Millisecond timer: a CPU write reloads the count and restarts the
  // prescaler, swallowing any tick due in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      ms    <= '0;
    end else if (we_ms) begin
      presc <= '0;
      ms    <= outM;
    end else if (tick) begin
      presc <= '0;
      ms    <= ms + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Output registers with a one-cycle update pulse per write, even if unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_reg <= '0;
      out_upd <= '0;
    end else begin
      for (int i = 0; i < N_OUT; i++) begin
        out_upd[i] <= writeM && out_hit[i];
        if (writeM && out_hit[i]) begin
          out_reg[i] <= outM;
        end
      end
    end
  end

  // Read mux back to the CPU; unmapped and screen-hole addresses read zero.
  always_comb begin
    inM = '0;
    case (sel)
      SEL_RAM: inM = ram_data_out;
      SEL_SW:  inM = sw_sync;
      SEL_BTN: inM = DATA_W'(btn_sync);
      SEL_EVT: inM = DATA_W'(evt);
      SEL_MS:  inM = ms;
      SEL_OUT: begin
        for (int i = 0; i < N_OUT; i++) begin
          if (out_hit[i]) inM = out_reg[i];
        end
      end
      default: inM = '0;
    endcase
  end

endmodule

// File: tb/tb_mmio_io_controller.sv
// Directed bench for mmio_io_controller, built with a 4 kHz clock setting so
// the millisecond prescaler divides by 4.
module tb_mmio_io_controller;

  logic              clk;
  logic              rst_n;
  logic [14:0]       addressM;
  logic [15:0]       outM;
  logic              writeM;
  logic [15:0]       inM;
  logic [13:0]       ram_addr;
  logic [15:0]       ram_data_in;
  logic              ram_we;
  logic [15:0]       ram_data_out;
  logic [15:0]       sw_raw;
  logic [4:0]        btn_raw;
  logic [1:0][15:0]  out_reg;
  logic [1:0]        out_upd;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] mem [0:16383];

  mmio_io_controller #(
    .DATA_W(16), .RAM_AW(14), .IO_BASE(15'h6000), .BTN_W(5),
    .N_OUT(2), .SYNC_STAGES(2), .CLK_HZ(4000)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .addressM     (addressM),
    .outM         (outM),
    .writeM       (writeM),
    .inM          (inM),
    .ram_addr     (ram_addr),
    .ram_data_in  (ram_data_in),
    .ram_we       (ram_we),
    .ram_data_out (ram_data_out),
    .sw_raw       (sw_raw),
    .btn_raw      (btn_raw),
    .out_reg      (out_reg),
    .out_upd      (out_upd)
  );

  // Clock and external data RAM model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_data_in;
  assign ram_data_out = mem[ram_addr];

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks: called at a negedge; the write occupies exactly one posedge.
  task automatic do_write(input logic [14:0] a, input logic [15:0] d);
    addressM = a;
    outM     = d;
    writeM   = 1'b1;
    @(negedge clk);
    writeM   = 1'b0;
  endtask

  task automatic rd(input logic [14:0] a, output logic [15:0] d);
    addressM = a;
    #1;
    d = inM;
  endtask

  task automatic test_reset;
    logic [15:0] d;
    rst_n = 1'b0; writeM = 1'b0; addressM = '0; outM = '0;
    sw_raw = '0; btn_raw = '0;
    mem[5] = 16'h5A5A;
    #2;
    for (int i = 0; i < 6; i++) begin
      rd(15'h6000 + 15'(i), d);
      n_checks++;
      if (d !== 16'h0000) begin n_fail++; $display("FAIL reset_io_read[%0d]: got %h exp 0000", i, d); end
    end
    rd(15'h0005, d);
    n_checks++;
    if (d !== 16'h5A5A) begin n_fail++; $display("FAIL reset_ram_passthru: got %h exp 5a5a", d); end
    n_checks++;
    if (out_reg !== 32'h0 || out_upd !== 2'b00) begin n_fail++; $display("FAIL reset_out: got %h/%b exp 0/00", out_reg, out_upd); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ram;
    logic [15:0] d;
    addressM = 15'h0010; outM = 16'h1234; writeM = 1'b1;
    #1;
    n_checks++;
    if (ram_we !== 1'b1 || ram_addr !== 14'h0010 || ram_data_in !== 16'h1234) begin
      n_fail++; $display("FAIL ram_write_strobe: got we=%b addr=%h data=%h exp 1/0010/1234", ram_we, ram_addr, ram_data_in);
    end
    @(negedge clk);
    writeM = 1'b0;
    #1;
    n_checks++;
    if (ram_we !== 1'b0) begin n_fail++; $display("FAIL ram_we_one_cycle: got %b exp 0", ram_we); end
    rd(15'h0010, d);
    n_checks++;
    if (d !== 16'h1234) begin n_fail++; $display("FAIL ram_readback: got %h exp 1234", d); end
    @(negedge clk);
  endtask

  task automatic test_switches;
    logic [15:0] d;
    sw_raw = 16'hA5A5; addressM = 15'h6000;
    @(negedge clk);
    #1;
    n_checks++;
    if (inM !== 16'h0000) begin n_fail++; $display("FAIL sw_sync_1edge: got %h exp 0000", inM); end
    @(negedge clk);
    #1;
    n_checks++;
    if (inM !== 16'hA5A5) begin n_fail++; $display("FAIL sw_sync_2edge: got %h exp a5a5", inM); end
    @(negedge clk);
    addressM = 15'h6000; outM = 16'hFFFF; writeM = 1'b1;
    #1;
    n_checks++;
    if (ram_we !== 1'b0) begin n_fail++; $display("FAIL sw_write_ram_we: got %b exp 0", ram_we); end
    @(negedge clk);
    writeM = 1'b0;
    do_write(15'h7000, 16'hBEEF);
    rd(15'h6000, d);
    n_checks++;
    if (d !== 16'hA5A5) begin n_fail++; $display("FAIL sw_write_ignored: got %h exp a5a5", d); end
    rd(15'h7000, d);
    n_checks++;
    if (d !== 16'h0000 || out_upd !== 2'b00) begin n_fail++; $display("FAIL unmapped_read: got %h/%b exp 0000/00", d, out_upd); end
    @(negedge clk);
  endtask

  task automatic test_buttons;
    logic [15:0] d;
    btn_raw = 5'b00100;
    @(negedge clk);
    @(negedge clk);
    rd(15'h6001, d);
    n_checks++;
    if (d !== 16'h0004) begin n_fail++; $display("FAIL btn_sync_level: got %h exp 0004", d); end
    rd(15'h6002, d);
    n_checks++;
    if (d !== 16'h0000) begin n_fail++; $display("FAIL evt_not_yet: got %h exp 0000", d); end
    @(negedge clk);
    rd(15'h6002, d);
    n_checks++;
    if (d !== 16'h0004) begin n_fail++; $display("FAIL evt_set: got %h exp 0004", d); end
    repeat (7) @(negedge clk);
    btn_raw = 5'b00000;
    repeat (4) @(negedge clk);
    rd(15'h6002, d);
    n_checks++;
    if (d !== 16'h0004) begin n_fail++; $display("FAIL evt_sticky: got %h exp 0004", d); end
    rd(15'h6001, d);
    n_checks++;
    if (d !== 16'h0000) begin n_fail++; $display("FAIL btn_released: got %h exp 0000", d); end
    do_write(15'h6002, 16'h0004);
    rd(15'h6002, d);
    n_checks++;
    if (d !== 16'h0000) begin n_fail++; $display("FAIL evt_w1c: got %h exp 0000", d); end
    // New edge lands on the same clock as a clear of that bit
    @(negedge clk);
    btn_raw = 5'b00100;
    repeat (2) @(negedge clk);
    do_write(15'h6002, 16'h0004);
    rd(15'h6002, d);
    n_checks++;
    if (d !== 16'h0004) begin n_fail++; $display("FAIL evt_set_wins: got %h exp 0004", d); end
    // Clear while held: no re-set from a steady level
    @(negedge clk);
    do_write(15'h6002, 16'h0004);
    repeat (3) @(negedge clk);
    rd(15'h6002, d);
    n_checks++;
    if (d !== 16'h0000) begin n_fail++; $display("FAIL evt_held_once: got %h exp 0000", d); end
    btn_raw = 5'b00000;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_ms_timer;
    logic [15:0] d;
    do_write(15'h6003, 16'h0000);
    repeat (11) @(negedge clk);
    rd(15'h6003, d);
    n_checks++;
    if (d !== 16'h0002) begin n_fail++; $display("FAIL ms_11cyc: got %h exp 0002", d); end
    @(negedge clk);
    rd(15'h6003, d);
    n_checks++;
    if (d !== 16'h0003) begin n_fail++; $display("FAIL ms_12cyc: got %h exp 0003", d); end
    @(negedge clk);
    do_write(15'h6003, 16'hFFFF);
    repeat (3) @(negedge clk);
    rd(15'h6003, d);
    n_checks++;
    if (d !== 16'hFFFF) begin n_fail++; $display("FAIL ms_preload: got %h exp ffff", d); end
    @(negedge clk);
    rd(15'h6003, d);
    n_checks++;
    if (d !== 16'h0000) begin n_fail++; $display("FAIL ms_wrap: got %h exp 0000", d); end
    // Write on the exact tick cycle: tick is dropped, prescaler restarts
    @(negedge clk);
    do_write(15'h6003, 16'h0000);
    repeat (3) @(negedge clk);
    do_write(15'h6003, 16'h0100);
    repeat (3) @(negedge clk);
    rd(15'h6003, d);
    n_checks++;
    if (d !== 16'h0100) begin n_fail++; $display("FAIL ms_write_wins: got %h exp 0100", d); end
    @(negedge clk);
    rd(15'h6003, d);
    n_checks++;
    if (d !== 16'h0101) begin n_fail++; $display("FAIL ms_after_reload: got %h exp 0101", d); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [15:0] d;
    do_write(15'h6004, 16'h00FF);
    n_checks++;
    if (out_upd !== 2'b01) begin n_fail++; $display("FAIL upd_first: got %b exp 01", out_upd); end
    do_write(15'h6005, 16'h0F0F);
    n_checks++;
    if (out_upd !== 2'b10) begin n_fail++; $display("FAIL upd_second: got %b exp 10", out_upd); end
    @(negedge clk);
    n_checks++;
    if (out_upd !== 2'b00) begin n_fail++; $display("FAIL upd_drop: got %b exp 00", out_upd); end
    n_checks++;
    if (out_reg !== {16'h0F0F, 16'h00FF}) begin n_fail++; $display("FAIL out_reg_value: got %h exp 0f0f00ff", out_reg); end
    rd(15'h6004, d);
    n_checks++;
    if (d !== 16'h00FF) begin n_fail++; $display("FAIL out0_read: got %h exp 00ff", d); end
    rd(15'h6005, d);
    n_checks++;
    if (d !== 16'h0F0F) begin n_fail++; $display("FAIL out1_read: got %h exp 0f0f", d); end
    @(negedge clk);
    do_write(15'h6004, 16'h00FF);
    n_checks++;
    if (out_upd !== 2'b01) begin n_fail++; $display("FAIL upd_same_value: got %b exp 01", out_upd); end
    @(negedge clk);
  endtask

  task automatic test_async_reset;
    logic [15:0] d;
    btn_raw = 5'b00001;
    repeat (4) @(negedge clk);
    btn_raw = 5'b00000;
    rd(15'h6002, d);
    n_checks++;
    if (d !== 16'h0001) begin n_fail++; $display("FAIL pre_reset_evt: got %h exp 0001", d); end
    @(negedge clk);
    addressM = 15'h6004; outM = 16'hDEAD; writeM = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_reg !== 32'h0 || out_upd !== 2'b00) begin n_fail++; $display("FAIL async_out_clear: got %h/%b exp 0/00", out_reg, out_upd); end
    writeM = 1'b0;
    rd(15'h6002, d);
    n_checks++;
    if (d !== 16'h0000) begin n_fail++; $display("FAIL async_evt_clear: got %h exp 0000", d); end
    rd(15'h6003, d);
    n_checks++;
    if (d !== 16'h0000) begin n_fail++; $display("FAIL async_ms_clear: got %h exp 0000", d); end
    addressM = 15'h6004; writeM = 1'b1;
    repeat (2) @(negedge clk);
    writeM = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (out_reg !== 32'h0) begin n_fail++; $display("FAIL write_in_reset_lost: got %h exp 0", out_reg); end
    addressM = 15'h4100; outM = 16'h7777; writeM = 1'b1;
    #1;
    n_checks++;
    if (ram_we !== 1'b0 || inM !== 16'h0000) begin n_fail++; $display("FAIL screen_hole: got we=%b inM=%h exp 0/0000", ram_we, inM); end
    @(negedge clk);
    writeM = 1'b0;
    @(negedge clk);
  endtask

  // Test sequence
  initial begin
    test_reset();
    test_ram();
    test_switches();
    test_buttons();
    test_ms_timer();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
